// File: rtl/clock_pkg.sv
`default_nettype none
// =====================================================================
// clock_pkg : shared BCD types, alarm states and BCD increment helper
// Rev 1.0
// =====================================================================
package clock_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZE   = 2'd3
    } alarm_state_t;

    localparam int         CLK_FREQ_DEFAULT = 50_000_000;
    localparam logic [7:0] MAX_HOUR_BCD     = 8'h23;
    localparam logic [7:0] MAX_MIN_BCD      = 8'h59;

    // Two-digit BCD +1 that wraps to 00 once the given maximum is reached.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
        logic [7:0] res;
        if (val == max) begin
            res = 8'h00;
        end else if (val[3:0] == 4'd9) begin
            res = {val[7:4] + 4'd1, 4'd0};
        end else begin
            res = {val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_tone_gen.sv
`default_nettype none
// =====================================================================
// alarm_tone_gen : registered square wave, high on restart, HALF cycles/phase
// Rev 1.0
// =====================================================================
module alarm_tone_gen #(
    parameter int HALF = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic restart,
    output logic tone
);

    localparam int            CW          = $clog2(HALF + 1);
    localparam logic [CW-1:0] C_HALF_LAST = CW'(HALF - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
            tone  <= 1'b0;
        end else if (restart) begin
            r_cnt <= '0;
            tone  <= 1'b1;
        end else if (enable) begin
            if (r_cnt == C_HALF_LAST) begin
                r_cnt <= '0;
                tone  <= ~tone;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
            tone  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alarm_controller.sv
`default_nettype none
// =====================================================================
// alarm_controller : HH:MM alarm with pulsed buzzer; snooze under ALARM_SNOOZE_EN
// Rev 1.0
// =====================================================================
module alarm_controller
    import clock_pkg::*;
#(
    parameter int CLK_FREQ       = CLK_FREQ_DEFAULT,
    parameter int BEEP_HZ        = 2,
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300
) (
    input  logic clk,
    input  logic reset_n,
    input  bcd_t h2,
    input  bcd_t h1,
    input  bcd_t m2,
    input  bcd_t m1,
    input  bcd_t s2,
    input  bcd_t s1,
    input  logic alarm_en,
    input  logic set_hour_p,
    input  logic set_min_p,
    input  logic stop_p,
    input  logic snooze_p,
    output bcd_t alarm_h2,
    output bcd_t alarm_h1,
    output bcd_t alarm_m2,
    output bcd_t alarm_m1,
    output logic armed,
    output logic ringing,
    output logic snoozing,
    output logic buzzer
);

    localparam int            HALF        = CLK_FREQ / (2 * BEEP_HZ);
    localparam int            RW          = $clog2(RING_SECONDS + 1);
    localparam logic [RW-1:0] C_RING_LAST = RW'(RING_SECONDS - 1);

    alarm_state_t  r_state, w_state_nx;
    logic [7:0]    r_alarm_hh, r_alarm_mm;
    bcd_t          r_s1_prev;
    logic [RW-1:0] r_ring_cnt, w_ring_cnt_nx;
    logic          w_sec_tick, w_match, w_enter_ring, w_set_ok;

`ifdef ALARM_SNOOZE_EN
    localparam int            SW         = $clog2(SNOOZE_SECONDS + 1);
    localparam logic [SW-1:0] C_SNZ_LOAD = SW'(SNOOZE_SECONDS);
    logic [SW-1:0] r_snz_cnt, w_snz_cnt_nx;
`else
    localparam int c_unused_snooze_seconds = SNOOZE_SECONDS;
    logic w_unused_snooze;
    assign w_unused_snooze = snooze_p;
    assign snoozing        = 1'b0;
`endif

    // Minute changes made via min_up leave s1 still, so they never produce a tick.
    assign w_sec_tick = (s1 != r_s1_prev);
    assign w_match    = w_sec_tick && (s2 == 4'd0) && (s1 == 4'd0) &&
                        ({h2, h1, m2, m1} == {r_alarm_hh, r_alarm_mm});
    assign w_set_ok   = (r_state == DISABLED) || (r_state == ARMED);

    always_comb begin
        w_state_nx    = r_state;
        w_enter_ring  = 1'b0;
        w_ring_cnt_nx = r_ring_cnt;
`ifdef ALARM_SNOOZE_EN
        w_snz_cnt_nx  = r_snz_cnt;
`endif
        if (!alarm_en) begin
            w_state_nx = DISABLED;
        end else begin
            case (r_state)
                DISABLED: w_state_nx = ARMED;
                ARMED: begin
                    if (w_match) begin
                        w_state_nx   = RINGING;
                        w_enter_ring = 1'b1;
                    end
                end
                RINGING: begin
                    if (stop_p) begin
                        w_state_nx = ARMED;
                    end
`ifdef ALARM_SNOOZE_EN
                    else if (snooze_p) begin
                        w_state_nx   = SNOOZE;
                        w_snz_cnt_nx = C_SNZ_LOAD;
                    end
`endif
                    else if (w_sec_tick) begin
                        if (r_ring_cnt == C_RING_LAST) begin
                            w_state_nx = ARMED;
                        end else begin
                            w_ring_cnt_nx = r_ring_cnt + 1'b1;
                        end
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (stop_p) begin
                        w_state_nx = ARMED;
                    end else if (w_sec_tick) begin
                        if (r_snz_cnt == SW'(1)) begin
                            w_state_nx   = RINGING;
                            w_enter_ring = 1'b1;
                        end else begin
                            w_snz_cnt_nx = r_snz_cnt - 1'b1;
                        end
                    end
                end
`endif
                default: w_state_nx = DISABLED;
            endcase
        end
        if (w_enter_ring) begin
            w_ring_cnt_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= DISABLED;
            r_alarm_hh <= 8'h00;
            r_alarm_mm <= 8'h00;
            r_s1_prev  <= 4'd0;
            r_ring_cnt <= '0;
            armed      <= 1'b0;
            ringing    <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            r_snz_cnt  <= '0;
            snoozing   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_s1_prev  <= s1;
            r_ring_cnt <= w_ring_cnt_nx;
            armed      <= (w_state_nx == ARMED);
            ringing    <= (w_state_nx == RINGING);
`ifdef ALARM_SNOOZE_EN
            r_snz_cnt  <= w_snz_cnt_nx;
            snoozing   <= (w_state_nx == SNOOZE);
`endif
            // Match above used the pre-increment alarm value.
            if (w_set_ok && set_hour_p) begin
                r_alarm_hh <= bcd_inc(r_alarm_hh, MAX_HOUR_BCD);
            end
            if (w_set_ok && set_min_p) begin
                r_alarm_mm <= bcd_inc(r_alarm_mm, MAX_MIN_BCD);
            end
        end
    end

    assign alarm_h2 = r_alarm_hh[7:4];
    assign alarm_h1 = r_alarm_hh[3:0];
    assign alarm_m2 = r_alarm_mm[7:4];
    assign alarm_m1 = r_alarm_mm[3:0];

    alarm_tone_gen #(
        .HALF (HALF)
    ) u_tone (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (w_state_nx == RINGING),
        .restart (w_enter_ring),
        .tone    (buzzer)
    );

endmodule
`default_nettype wire

// File: tb/tb_alarm_controller.sv
`default_nettype none
// =====================================================================
// tb_alarm_controller : scoreboard bench with a seconds/cycles reference model
// Rev 1.0
// =====================================================================
module tb_alarm_controller;

    localparam int CF   = 20;
    localparam int BH   = 2;
    localparam int RS   = 3;
    localparam int SS   = 4;
    localparam int HALF = CF / (2 * BH);
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif
    localparam int ST_DIS = 0, ST_ARM = 1, ST_RING = 2, ST_SNZ = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n = 1'b0, alarm_en = 1'b1;
    logic       set_hour_p = 1'b0, set_min_p = 1'b0, stop_p = 1'b0, snooze_p = 1'b0;
    logic [3:0] h2 = 0, h1 = 0, m2 = 0, m1 = 0, s2 = 0, s1 = 0;
    logic [3:0] alarm_h2, alarm_h1, alarm_m2, alarm_m1;
    logic       armed, ringing, snoozing, buzzer;

    alarm_controller #(
        .CLK_FREQ(CF), .BEEP_HZ(BH), .RING_SECONDS(RS), .SNOOZE_SECONDS(SS)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .h2(h2), .h1(h1), .m2(m2), .m1(m1), .s2(s2), .s1(s1),
        .alarm_en(alarm_en), .set_hour_p(set_hour_p), .set_min_p(set_min_p),
        .stop_p(stop_p), .snooze_p(snooze_p),
        .alarm_h2(alarm_h2), .alarm_h1(alarm_h1), .alarm_m2(alarm_m2), .alarm_m1(alarm_m1),
        .armed(armed), .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
    );

    typedef struct packed {
        logic [3:0] ah2, ah1, am2, am1;
        logic       arm, ring, snz, buz;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    string cur_tag = "init";
    int    n_tests = 0, n_fail = 0;

    // Stimulus-side wall clock and control levels
    int hh = 0, mm = 0, ss = 0;
    bit rst_lvl = 1'b0, en_lvl = 1'b1;

    // Reference model: alarm as integer hour/minute, ringing as elapsed seconds/cycles
    int m_state = ST_DIS, m_ah = 0, m_am = 0, m_prev_s1 = 0;
    int m_ring_secs = 0, m_snz_left = 0, m_ring_cyc = 0;
    bit m_buzz = 1'b0;

    task automatic set_time(input int h, input int m, input int s);
        hh = h; mm = m; ss = s;
    endtask

    task automatic tick_time();
        ss = ss + 1;
        if (ss == 60) begin ss = 0; mm = mm + 1; end
        if (mm == 60) begin mm = 0; hh = (hh + 1) % 24; end
    endtask

    task automatic step(input bit hp, input bit mp, input bit sp, input bit zp);
        bit   tick, match, enter;
        int   ns;
        exp_t e;
        @(negedge clk);
        reset_n    = rst_lvl;
        alarm_en   = en_lvl;
        set_hour_p = hp;
        set_min_p  = mp;
        stop_p     = sp;
        snooze_p   = zp;
        h2 = 4'(hh / 10); h1 = 4'(hh % 10);
        m2 = 4'(mm / 10); m1 = 4'(mm % 10);
        s2 = 4'(ss / 10); s1 = 4'(ss % 10);
        if (!rst_lvl) begin
            m_state = ST_DIS; m_ah = 0; m_am = 0; m_prev_s1 = 0;
            m_ring_secs = 0; m_snz_left = 0; m_ring_cyc = 0; m_buzz = 1'b0;
        end else begin
            tick      = (ss % 10) != m_prev_s1;
            m_prev_s1 = ss % 10;
            match     = tick && ss == 0 && hh == m_ah && mm == m_am;
            ns        = m_state;
            enter     = 1'b0;
            if (!en_lvl) begin
                ns = ST_DIS;
            end else if (m_state == ST_DIS) begin
                ns = ST_ARM;
            end else if (m_state == ST_ARM) begin
                if (match) begin ns = ST_RING; enter = 1'b1; end
            end else if (m_state == ST_RING) begin
                if (sp) begin
                    ns = ST_ARM;
                end else if (SNZ_EN && zp) begin
                    ns = ST_SNZ; m_snz_left = SS;
                end else if (tick) begin
                    m_ring_secs++;
                    if (m_ring_secs >= RS) ns = ST_ARM;
                end
            end else begin
                if (sp) begin
                    ns = ST_ARM;
                end else if (tick) begin
                    m_snz_left--;
                    if (m_snz_left == 0) begin ns = ST_RING; enter = 1'b1; end
                end
            end
            if (m_state == ST_DIS || m_state == ST_ARM) begin
                if (hp) m_ah = (m_ah + 1) % 24;
                if (mp) m_am = (m_am + 1) % 60;
            end
            if (enter) m_ring_secs = 0;
            if (ns == ST_RING) begin
                m_ring_cyc = enter ? 0 : m_ring_cyc + 1;
                m_buzz     = ((m_ring_cyc / HALF) % 2) == 0;
            end else begin
                m_buzz = 1'b0;
            end
            m_state = ns;
        end
        e.ah2  = 4'(m_ah / 10); e.ah1 = 4'(m_ah % 10);
        e.am2  = 4'(m_am / 10); e.am1 = 4'(m_am % 10);
        e.arm  = (m_state == ST_ARM);
        e.ring = (m_state == ST_RING);
        e.snz  = (m_state == ST_SNZ);
        e.buz  = m_buzz;
        exp_q.push_back(e);
        tag_q.push_back(cur_tag);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic trigger();
        set_time(7, 29, 59); idle(1);
        set_time(7, 30, 0);  idle(3);
    endtask

    // Monitor: compares each outstanding expectation just after the edge it describes
    exp_t  mon_e, mon_a;
    string mon_t;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_t = tag_q.pop_front();
                mon_a = {alarm_h2, alarm_h1, alarm_m2, alarm_m1, armed, ringing, snoozing, buzzer};
                n_tests++;
                if (mon_a !== mon_e) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got alarm=%h%h:%h%h arm=%b ring=%b snz=%b buz=%b, want alarm=%h%h:%h%h arm=%b ring=%b snz=%b buz=%b",
                             mon_t, $time, mon_a.ah2, mon_a.ah1, mon_a.am2, mon_a.am1,
                             mon_a.arm, mon_a.ring, mon_a.snz, mon_a.buz,
                             mon_e.ah2, mon_e.ah1, mon_e.am2, mon_e.am1,
                             mon_e.arm, mon_e.ring, mon_e.snz, mon_e.buz);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hp, mp, sp, zp;
        int t;
        cur_tag = "reset";       rst_lvl = 1'b0; en_lvl = 1'b1; idle(2);
        cur_tag = "arm_release"; rst_lvl = 1'b1; idle(1);
        cur_tag = "set_hour";    repeat (7)  step(1'b1, 1'b0, 1'b0, 1'b0);
        cur_tag = "set_min";     repeat (30) step(1'b0, 1'b1, 1'b0, 1'b0);
        cur_tag = "hour_wrap";   repeat (24) step(1'b1, 1'b0, 1'b0, 1'b0);
        cur_tag = "min_wrap";    repeat (30) step(1'b0, 1'b1, 1'b0, 1'b0);
        cur_tag = "set_min2";    repeat (30) step(1'b0, 1'b1, 1'b0, 1'b0);
        cur_tag = "trigger";     trigger();
        cur_tag = "tone";        idle(22);
        cur_tag = "set_in_ring"; step(1'b0, 1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0);
        cur_tag = "timeout";
        repeat (3) begin tick_time(); idle(2); end
        cur_tag = "min_up_no_ring";
        set_time(7, 29, 0); idle(2);
        set_time(7, 30, 0); idle(4);
        cur_tag = "snooze";      trigger(); step(1'b0, 1'b0, 1'b0, 1'b1); idle(2);
        repeat (4) begin tick_time(); idle(2); end
        idle(2);
        cur_tag = "stop_and_snooze"; step(1'b0, 1'b0, 1'b1, 1'b1); idle(2);
        cur_tag = "stop_ring";   trigger(); step(1'b0, 1'b0, 1'b1, 1'b0); idle(2);
        cur_tag = "disable";     trigger(); en_lvl = 1'b0; idle(2); en_lvl = 1'b1; idle(2);
        cur_tag = "reset_mid_ring"; trigger(); rst_lvl = 1'b0; idle(1); rst_lvl = 1'b1; idle(2);

        cur_tag = "random";
        for (int i = 0; i < 3000; i++) begin
            if (en_lvl && $urandom_range(0, 299) == 0) en_lvl = 1'b0;
            else if (!en_lvl && $urandom_range(0, 19) == 0) en_lvl = 1'b1;
            if ($urandom_range(0, 149) == 0) begin
                t  = (m_ah * 3600 + m_am * 60 - int'($urandom_range(1, 3)) + 86400) % 86400;
                hh = t / 3600; mm = (t / 60) % 60; ss = t % 60;
            end else if ($urandom_range(0, 2) == 0) begin
                tick_time();
            end
            rst_lvl = ($urandom_range(0, 999) != 0);
            hp = ($urandom_range(0, 99) < 2);
            mp = ($urandom_range(0, 99) < 2);
            sp = ($urandom_range(0, 99) < 1);
            zp = ($urandom_range(0, 99) < 3);
            step(hp, mp, sp, zp);
        end
        rst_lvl = 1'b1;
        idle(1);

        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
Alarm stage that sits directly downstream of the clock counter/BCD stage. It consumes the six live BCD time digits (HH:MM:SS) and holds a user-set alarm time (HH:MM, BCD). When the time matches, it drives a pulsed buzzer with snooze, stop and timeout handling.
Its alarm digits are exported so the top level can mux them onto the 7-segment decoders.

Parameters:
CLK_FREQ, 50_000_000, clk frequency in Hz
BEEP_HZ, 2, buzzer square-wave frequency while ringing
RING_SECONDS, 60, auto-stop after this many seconds of ringing
SNOOZE_SECONDS, 300, snooze length in seconds

Ports:
clk  in  1  board clock
reset_n  in  1  synchronous, active-low reset
h2,h1,m2,m1,s2,s1  in  4 each  live time digits, BCD
alarm_en  in  1  level (switch); 0 forces DISABLED
set_hour_p  in  1  single-cycle pulse: alarm hour +1
set_min_p  in  1  single-cycle pulse: alarm minute +1
stop_p  in  1  single-cycle pulse: stop ringing/snooze
snooze_p  in  1  single-cycle pulse: snooze
alarm_h2,alarm_h1,alarm_m2,alarm_m1  out  4 each  alarm time, BCD
armed  out  1  state==ARMED
ringing  out  1  state==RINGING
snoozing  out  1  state==SNOOZE
buzzer  out  1  tone output

Behaviour:
- One clock domain: clk. Reset is synchronous and active-low (reset_n). All outputs are registered.
- Reset values: state DISABLED; alarm time 00:00; armed, ringing, snoozing and buzzer all 0; internal counters 0; s1_prev = 0.
- Second tick: sec_tick = (s1 != s1_prev). s1_prev is updated every cycle.
- Match pulse: match = sec_tick && s2==0 && s1==0 && {h2,h1,m2,m1}=={alarm digits}.
  - Setting the clock with min_up produces no s1 change, so it never triggers.
- State transitions (priority top-down):
  - Any state with alarm_en=0: go to DISABLED next cycle.
  - DISABLED with alarm_en=1: go to ARMED.
  - ARMED on match: go to RINGING; clear ring_cnt and tone counter.
  - RINGING:
    - stop_p: go to ARMED. stop_p wins over a simultaneous snooze_p.
    - Else snooze_p: go to SNOOZE; load snz_cnt = SNOOZE_SECONDS.
    - Else on sec_tick with ring_cnt==RING_SECONDS-1: go to ARMED.
    - Else on sec_tick: ring_cnt+1.
  - SNOOZE:
    - stop_p: go to ARMED.
    - On sec_tick with snz_cnt==1: go to RINGING; clear ring_cnt and tone counter.
    - Else on sec_tick: snz_cnt-1.
- Latency: time digits reaching HH:MM:00 in cycle N gives ringing=1 and buzzer=1 in cycle N+1.
- Alarm setting:
  - set_hour_p and set_min_p are accepted only in DISABLED or ARMED; ignored in RINGING and SNOOZE.
  - Hour counts BCD 00..23 and wraps 23 to 00.
  - Minute counts BCD 00..59 and wraps 59 to 00 with no carry into the hour.
  - If both pulses arrive in the same cycle, both apply.
  - A pulse that arrives in the same cycle as a match: the increment applies, and the match is evaluated against the pre-increment value.
- Buzzer:
  - 0 outside RINGING.
  - In RINGING it toggles every HALF = CLK_FREQ/(2*BEEP_HZ) cycles.
  - It goes to 1 on the RINGING entry cycle.
- Counter widths: sized with $clog2 of the parameter; no overflow is reachable.
- Reset mid-ring: all outputs return to reset values the cycle after reset_n=0 is sampled.

Optional Feature:
- Macro: ALARM_SNOOZE_EN.
- Defined: SNOOZE state, snz_cnt and snooze_p handling are present as described above.
- Undefined:
  - snooze_p is ignored; snoozing is tied to 0; SNOOZE_SECONDS is unused.
  - RINGING leaves only by stop_p, timeout or alarm_en=0.

Decomposition:
- Package clock_pkg:
  - typedef bcd_t (logic[3:0]).
  - enum alarm_state_t {DISABLED, ARMED, RINGING, SNOOZE}.
  - Constants CLK_FREQ_DEFAULT, MAX_HOUR_BCD (8'h23), MAX_MIN_BCD (8'h59).
- Sub-module alarm_tone_gen:
  - Inputs: clk, reset_n, enable, restart.
  - Output: registered square wave with half-period counter.

Test Plan:
(bench: CLK_FREQ=20, BEEP_HZ=2 so HALF=5; RING_SECONDS=3; SNOOZE_SECONDS=4)
- Reset: hold reset_n=0 for 2 cycles with alarm_en=1 -> alarm digits 0,0,0,0, buzzer=0; armed=1 on the first cycle after release.
- Set: 7 set_hour_p and 30 set_min_p -> alarm 07:30. Then 24 set_hour_p -> 07:30. Then 30 set_min_p -> 07:00 (hour unchanged).
- Trigger: alarm 07:30; drive 07:29:59 then 07:30:00 -> ringing=1 next cycle; buzzer 1 for 5 cycles, 0 for 5, repeating. Setting time to 07:30:00 via min_up (s1 steady) -> no ring.
- Timeout: while ringing, 3 s1 changes -> armed=1, buzzer=0. set_min_p during ringing -> alarm digits unchanged.
- Snooze (ALARM_SNOOZE_EN):
  - snooze_p -> snoozing=1, buzzer=0.
  - 4 s1 changes -> ringing=1.
  - stop_p and snooze_p in the same cycle -> armed=1.
- Disable: alarm_en=0 mid-ring -> ringing=0, buzzer=0 next cycle. alarm_en=1 -> armed next cycle.
